cluster_bus_isolate_ctrl: RTL and testbench
===========================================

// Module: cluster_bus_isolate_ctrl
// PURPOSE
//  Sits on one cluster-bus slave port, upstream of the xbar. Gates new AW/AR handshakes.
//  Limits outstanding reads/writes to a programmable ceiling.
//  On isolate_req_i it stops admitting new bursts, drains in-flight ones, then flags isolated_o.
//  Used ahead of cluster clock-gating/power-down, and as a per-port transaction throttle.
// PARAMETERS
//  MaxWrTxns  8  max outstanding write bursts (AW accepted, B not yet accepted); >=1
//  MaxRdTxns  8  max outstanding read bursts (AR accepted, last R not yet accepted); >=1
//  CntW       $clog2(max(MaxWrTxns,MaxRdTxns)+1)  localparam, counter width
// PORTS
//  clk_i          in   1     clock
//  rst_ni         in   1     async reset, active low
//  isolate_req_i  in   1     level: request isolation; deassert to release
//  isolated_o     out  1     port drained and gated
//  busy_o         out  1     any transaction outstanding (wr_cnt_o!=0 | rd_cnt_o!=0)
//  wr_cnt_o       out  CntW  outstanding writes
//  rd_cnt_o       out  CntW  outstanding reads
//  aw_valid_i/aw_ready_o  in/out  1  upstream AW handshake
//  aw_valid_o/aw_ready_i  out/in  1  downstream (xbar) AW handshake
//  ar_valid_i/ar_ready_o  in/out  1  upstream AR handshake
//  ar_valid_o/ar_ready_i  out/in  1  downstream AR handshake
//  b_valid_i, b_ready_i   in  1  B handshake observed (passes through externally)
//  r_valid_i, r_ready_i, r_last_i  in  1  R handshake observed
// BEHAVIOUR
//  Reset: state=RUN, wr_cnt/rd_cnt=0, aw_hold/ar_hold=0, isolated_o=0, busy_o=0.
//  Gate (AW; AR identical with rd_cnt, MaxRdTxns, ar_*):
//   aw_open = aw_hold | (state==RUN & wr_cnt<MaxWrTxns)
//   aw_valid_o = aw_valid_i & aw_open
//   aw_ready_o = aw_ready_i & aw_open
//   Combinational, zero latency. W channel never gated.
//  AXI stability: aw_hold is set when aw_valid_o=1 & aw_ready_i=0.
//   It clears on the AW handshake, keeping the gate open so an asserted valid is never withdrawn.
//  Counters, updated on the registered clock edge:
//   wr_cnt +1 on an AW handshake (aw_valid_o & aw_ready_i); -1 on b_valid_i & b_ready_i.
//   rd_cnt +1 on an AR handshake; -1 on r_valid_i & r_ready_i & r_last_i.
//   Simultaneous inc and dec leaves the count unchanged.
//   Overflow is impossible by the gate.
//   Decrement at 0 is a protocol error: the count stays 0 and an assertion fires (sim only).
//  FSM:
//   RUN -> DRAIN when isolate_req_i=1.
//   DRAIN: gate closed except held beats.
//    -> ISOLATED when wr_cnt==0 & rd_cnt==0 & !aw_hold & !ar_hold & no AW/AR handshake this cycle.
//    -> RUN if isolate_req_i drops first.
//   ISOLATED: isolated_o=1 (registered, asserted the cycle after entry).
//    -> RUN when isolate_req_i=0; isolated_o falls in the same cycle the state leaves.
//  isolate_req_i high with nothing outstanding: isolated_o rises 2 cycles after the request edge.
//  Sequence: RUN, then DRAIN, then ISOLATED.
//  busy_o is registered from the next-state counters, so it is valid the cycle after the handshake.
//  Async reset mid-operation returns everything to the reset values.
//   Outstanding counts are lost; resetting this block together with the bus is mandatory.
// TESTING
//  T1: MaxWrTxns=2. Issue 3 AWs with aw_ready_i=1 and B withheld -> 2 accepted, wr_cnt_o=2.
//      3rd AW sees aw_ready_o=0 and aw_valid_o=0. One B -> 3rd AW accepted next cycle, wr_cnt_o=2.
//  T2: aw_valid_i=1, aw_ready_i=0 for 3 cycles, isolate_req_i rises in cycle 1.
//      -> aw_valid_o stays 1 until aw_ready_i=1. Then wr_cnt_o=1 and the state stays DRAIN.
//  T3: rd_cnt=2, isolate_req_i=1, R bursts of 4 beats each.
//      -> isolated_o=0 until the second r_last handshake. It is 1 one cycle later; new ARs are blocked.
//  T4: Same-cycle AW handshake and B handshake at wr_cnt=1 -> wr_cnt_o stays 1.
//      Same-cycle AR handshake and last R handshake -> rd_cnt_o unchanged.
//  T5: isolate_req_i pulses for 1 cycle with wr_cnt=3 (DRAIN entered, then released).
//      -> back to RUN, isolated_o never 1, AW accepted immediately after.
//  T6: rst_ni asserted with rd_cnt=2 in DRAIN.
//      -> all outputs at reset values asynchronously; after release a new AR is accepted.

Source files
------------

// File: rtl/cluster_bus_isolate_ctrl.sv
// Cluster-bus slave-port isolation and outstanding-transaction throttle.
// Gates new AW/AR handshakes, drains in-flight bursts, then reports isolation.
module cluster_bus_isolate_ctrl #(
    parameter int unsigned MaxWrTxns = 8,
    parameter int unsigned MaxRdTxns = 8,
    localparam int unsigned MaxTxns  = (MaxWrTxns > MaxRdTxns) ? MaxWrTxns : MaxRdTxns,
    localparam int unsigned CntW     = $clog2(MaxTxns + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            isolate_req_i,
    output logic            isolated_o,
    output logic            busy_o,
    output logic [CntW-1:0] wr_cnt_o,
    output logic [CntW-1:0] rd_cnt_o,
    input  logic            aw_valid_i,
    output logic            aw_ready_o,
    output logic            aw_valid_o,
    input  logic            aw_ready_i,
    input  logic            ar_valid_i,
    output logic            ar_ready_o,
    output logic            ar_valid_o,
    input  logic            ar_ready_i,
    input  logic            b_valid_i,
    input  logic            b_ready_i,
    input  logic            r_valid_i,
    input  logic            r_ready_i,
    input  logic            r_last_i
);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        ISOLATED
    } state_e;

    localparam logic [CntW-1:0] WrMax = CntW'(MaxWrTxns);
    localparam logic [CntW-1:0] RdMax = CntW'(MaxRdTxns);
    localparam logic [CntW-1:0] One   = CntW'(1);

    state_e          state_q, state_d;
    logic [CntW-1:0] wr_cnt_q, wr_cnt_d;
    logic [CntW-1:0] rd_cnt_q, rd_cnt_d;
    logic            aw_hold_q, aw_hold_d;
    logic            ar_hold_q, ar_hold_d;
    logic            isolated_q;
    logic            busy_q;

    logic aw_open, ar_open;
    logic aw_hs, ar_hs, b_hs, r_last_hs;

    // A held beat keeps its gate open regardless of state or ceiling.
    assign aw_open = aw_hold_q | ((state_q == RUN) && (wr_cnt_q < WrMax));
    assign ar_open = ar_hold_q | ((state_q == RUN) && (rd_cnt_q < RdMax));

    assign aw_valid_o = aw_valid_i & aw_open;
    assign aw_ready_o = aw_ready_i & aw_open;
    assign ar_valid_o = ar_valid_i & ar_open;
    assign ar_ready_o = ar_ready_i & ar_open;

    assign aw_hs     = aw_valid_o & aw_ready_i;
    assign ar_hs     = ar_valid_o & ar_ready_i;
    assign b_hs      = b_valid_i & b_ready_i;
    assign r_last_hs = r_valid_i & r_ready_i & r_last_i;

    assign aw_hold_d = (aw_hold_q | aw_valid_o) & ~aw_hs;
    assign ar_hold_d = (ar_hold_q | ar_valid_o) & ~ar_hs;

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        if (aw_hs && !b_hs) begin
            wr_cnt_d = wr_cnt_q + One;
        end else if (!aw_hs && b_hs && (wr_cnt_q != '0)) begin
            wr_cnt_d = wr_cnt_q - One;
        end
    end

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        if (ar_hs && !r_last_hs) begin
            rd_cnt_d = rd_cnt_q + One;
        end else if (!ar_hs && r_last_hs && (rd_cnt_q != '0)) begin
            rd_cnt_d = rd_cnt_q - One;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (isolate_req_i) state_d = DRAIN;
            end
            DRAIN: begin
                if (!isolate_req_i) begin
                    state_d = RUN;
                end else if ((wr_cnt_q == '0) && (rd_cnt_q == '0) && !aw_hold_q && !ar_hold_q
                             && !aw_hs && !ar_hs) begin
                    state_d = ISOLATED;
                end
            end
            ISOLATED: begin
                if (!isolate_req_i) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= RUN;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            aw_hold_q  <= 1'b0;
            ar_hold_q  <= 1'b0;
            isolated_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            aw_hold_q  <= aw_hold_d;
            ar_hold_q  <= ar_hold_d;
            isolated_q <= (state_d == ISOLATED);
            busy_q     <= (wr_cnt_d != '0) || (rd_cnt_d != '0);
        end
    end

    assign isolated_o = isolated_q;
    assign busy_o     = busy_q;
    assign wr_cnt_o   = wr_cnt_q;
    assign rd_cnt_o   = rd_cnt_q;

    // A response with nothing outstanding means the bus and this block disagree.
    a_no_b_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(b_hs && !aw_hs && (wr_cnt_q == '0)));
    a_no_r_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(r_last_hs && !ar_hs && (rd_cnt_q == '0)));

endmodule

// File: tb/tb_cluster_bus_isolate_ctrl.sv
// Directed scoreboard bench for cluster_bus_isolate_ctrl: ceiling 2 (u_a) and ceiling 4 (u_b).
module tb_cluster_bus_isolate_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, isolate_req;
    logic aw_valid_i, aw_ready_i, ar_valid_i, ar_ready_i;
    logic b_valid, b_ready, r_valid, r_ready, r_last;

    logic       isolated_a, busy_a, aw_ready_o_a, aw_valid_o_a, ar_ready_o_a, ar_valid_o_a;
    logic [1:0] wr_cnt_a, rd_cnt_a;
    logic       isolated_b, busy_b, aw_ready_o_b, aw_valid_o_b, ar_ready_o_b, ar_valid_o_b;
    logic [2:0] wr_cnt_b, rd_cnt_b;

    cluster_bus_isolate_ctrl #(.MaxWrTxns(2), .MaxRdTxns(2)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .isolate_req_i(isolate_req),
        .isolated_o(isolated_a), .busy_o(busy_a), .wr_cnt_o(wr_cnt_a), .rd_cnt_o(rd_cnt_a),
        .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o_a), .aw_valid_o(aw_valid_o_a), .aw_ready_i(aw_ready_i),
        .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o_a), .ar_valid_o(ar_valid_o_a), .ar_ready_i(ar_ready_i),
        .b_valid_i(b_valid), .b_ready_i(b_ready),
        .r_valid_i(r_valid), .r_ready_i(r_ready), .r_last_i(r_last)
    );

    cluster_bus_isolate_ctrl #(.MaxWrTxns(4), .MaxRdTxns(4)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .isolate_req_i(isolate_req),
        .isolated_o(isolated_b), .busy_o(busy_b), .wr_cnt_o(wr_cnt_b), .rd_cnt_o(rd_cnt_b),
        .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o_b), .aw_valid_o(aw_valid_o_b), .aw_ready_i(aw_ready_i),
        .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o_b), .ar_valid_o(ar_valid_o_b), .ar_ready_i(ar_ready_i),
        .b_valid_i(b_valid), .b_ready_i(b_ready),
        .r_valid_i(r_valid), .r_ready_i(r_ready), .r_last_i(r_last)
    );

    int          total = 0;
    int          bad   = 0;
    string       tag_q[$];
    logic [31:0] val_q[$];

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        val_q.push_back(v);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        total++;
        if (val_q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty: got %0d expected nothing queued", obs);
        end else begin
            t = tag_q.pop_front();
            e = val_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s: got %0d expected %0d", t, obs, e);
            end
        end
    endtask

    task automatic idle_inputs();
        isolate_req = 1'b0;
        aw_valid_i  = 1'b0; aw_ready_i = 1'b0;
        ar_valid_i  = 1'b0; ar_ready_i = 1'b0;
        b_valid     = 1'b0; b_ready    = 1'b0;
        r_valid     = 1'b0; r_ready    = 1'b0; r_last = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        #1;
        // reset values
        push("rst_isolated", 0); push("rst_busy", 0); push("rst_wr", 0); push("rst_rd", 0);
        pop_chk(32'(isolated_a)); pop_chk(32'(busy_a)); pop_chk(32'(wr_cnt_a)); pop_chk(32'(rd_cnt_a));
        cyc();
        rst_n = 1'b1;

        // T1: write ceiling of 2
        aw_valid_i = 1'b1; aw_ready_i = 1'b1; #1;
        push("t1_awv_first", 1); pop_chk(32'(aw_valid_o_a));
        cyc(); cyc(); #1;
        push("t1_wr_full", 2); push("t1_awr_blocked", 0); push("t1_awv_blocked", 0); push("t1_busy", 1);
        pop_chk(32'(wr_cnt_a)); pop_chk(32'(aw_ready_o_a)); pop_chk(32'(aw_valid_o_a)); pop_chk(32'(busy_a));
        b_valid = 1'b1; b_ready = 1'b1;
        cyc();
        b_valid = 1'b0; b_ready = 1'b0; #1;
        push("t1_wr_after_b", 1); push("t1_awv_reopen", 1); push("t1_awr_reopen", 1);
        pop_chk(32'(wr_cnt_a)); pop_chk(32'(aw_valid_o_a)); pop_chk(32'(aw_ready_o_a));
        cyc(); #1;
        push("t1_wr_final", 2); pop_chk(32'(wr_cnt_a));

        // T2: held AW survives isolation request
        do_reset();
        aw_valid_i = 1'b1; aw_ready_i = 1'b0; #1;
        push("t2_awv_c0", 1); pop_chk(32'(aw_valid_o_a));
        cyc();
        isolate_req = 1'b1; #1;
        push("t2_awv_c1", 1); pop_chk(32'(aw_valid_o_a));
        cyc(); #1;
        push("t2_awv_c2", 1); pop_chk(32'(aw_valid_o_a));
        cyc();
        aw_ready_i = 1'b1; #1;
        push("t2_awv_c3", 1); push("t2_awr_c3", 1);
        pop_chk(32'(aw_valid_o_a)); pop_chk(32'(aw_ready_o_a));
        cyc();
        aw_valid_i = 1'b0; aw_ready_i = 1'b0; #1;
        push("t2_wr", 1); push("t2_iso", 0);
        pop_chk(32'(wr_cnt_a)); pop_chk(32'(isolated_a));
        cyc();
        aw_valid_i = 1'b1; aw_ready_i = 1'b1; #1;
        push("t2_drain_awv", 0); push("t2_drain_awr", 0); push("t2_iso_stay", 0);
        pop_chk(32'(aw_valid_o_a)); pop_chk(32'(aw_ready_o_a)); pop_chk(32'(isolated_a));

        // T3: drain two 4-beat read bursts
        do_reset();
        ar_valid_i = 1'b1; ar_ready_i = 1'b1;
        cyc(); cyc();
        ar_valid_i = 1'b0; ar_ready_i = 1'b0; #1;
        push("t3_rd2", 2); pop_chk(32'(rd_cnt_a));
        isolate_req = 1'b1;
        cyc();
        r_valid = 1'b1; r_ready = 1'b1;
        for (int burst = 0; burst < 2; burst++) begin
            for (int beat = 0; beat < 4; beat++) begin
                r_last = (beat == 3); #1;
                push("t3_iso_beat", 0); pop_chk(32'(isolated_a));
                cyc();
            end
        end
        r_valid = 1'b0; r_ready = 1'b0; r_last = 1'b0; #1;
        push("t3_iso_edge", 0); push("t3_rd0", 0);
        pop_chk(32'(isolated_a)); pop_chk(32'(rd_cnt_a));
        cyc();
        ar_valid_i = 1'b1; ar_ready_i = 1'b1; #1;
        push("t3_iso", 1); push("t3_arv_blocked", 0); push("t3_arr_blocked", 0); push("t3_busy", 0);
        pop_chk(32'(isolated_a)); pop_chk(32'(ar_valid_o_a)); pop_chk(32'(ar_ready_o_a)); pop_chk(32'(busy_a));
        isolate_req = 1'b0; ar_valid_i = 1'b0;
        cyc(); #1;
        push("t3_release", 0); pop_chk(32'(isolated_a));

        // T4: simultaneous increment and decrement
        do_reset();
        aw_valid_i = 1'b1; aw_ready_i = 1'b1;
        cyc(); #1;
        push("t4_wr1", 1); pop_chk(32'(wr_cnt_a));
        b_valid = 1'b1; b_ready = 1'b1;
        cyc(); #1;
        push("t4_wr_same", 1); pop_chk(32'(wr_cnt_a));
        aw_valid_i = 1'b0; aw_ready_i = 1'b0; b_valid = 1'b0; b_ready = 1'b0;
        ar_valid_i = 1'b1; ar_ready_i = 1'b1;
        cyc(); #1;
        push("t4_rd1", 1); pop_chk(32'(rd_cnt_a));
        r_valid = 1'b1; r_ready = 1'b1; r_last = 1'b1;
        cyc(); #1;
        push("t4_rd_same", 1); pop_chk(32'(rd_cnt_a));
        r_last = 1'b0;
        cyc(); #1;
        push("t4_rd_nonlast", 2); pop_chk(32'(rd_cnt_a));

        // T5: one-cycle isolation pulse with three writes outstanding (ceiling 4)
        do_reset();
        aw_valid_i = 1'b1; aw_ready_i = 1'b1;
        cyc(); cyc(); cyc(); #1;
        push("t5_wr3", 3); pop_chk(32'(wr_cnt_b));
        isolate_req = 1'b1; aw_valid_i = 1'b0;
        cyc();
        isolate_req = 1'b0; aw_valid_i = 1'b1; #1;
        push("t5_drain_closed", 0); push("t5_iso_drain", 0);
        pop_chk(32'(aw_valid_o_b)); pop_chk(32'(isolated_b));
        cyc(); #1;
        push("t5_run_awv", 1); push("t5_run_awr", 1); push("t5_iso_run", 0);
        pop_chk(32'(aw_valid_o_b)); pop_chk(32'(aw_ready_o_b)); pop_chk(32'(isolated_b));
        cyc(); #1;
        push("t5_wr4", 4); pop_chk(32'(wr_cnt_b));

        // T6: asynchronous reset while draining reads
        do_reset();
        ar_valid_i = 1'b1; ar_ready_i = 1'b1;
        cyc(); cyc();
        ar_valid_i = 1'b0;
        isolate_req = 1'b1;
        cyc(); #1;
        push("t6_rd2", 2); pop_chk(32'(rd_cnt_a));
        #2 rst_n = 1'b0;
        #1;
        push("t6_rd_rst", 0); push("t6_busy_rst", 0); push("t6_iso_rst", 0); push("t6_arr_rst", 1);
        pop_chk(32'(rd_cnt_a)); pop_chk(32'(busy_a)); pop_chk(32'(isolated_a)); pop_chk(32'(ar_ready_o_a));
        @(negedge clk);
        rst_n = 1'b1; isolate_req = 1'b0; ar_valid_i = 1'b1; ar_ready_i = 1'b1; #1;
        push("t6_arv_after", 1); pop_chk(32'(ar_valid_o_a));
        cyc(); #1;
        push("t6_rd1", 1); pop_chk(32'(rd_cnt_a));

        // T7: isolation with nothing outstanding
        do_reset();
        isolate_req = 1'b1;
        cyc(); #1;
        push("t7_iso_c1", 0); pop_chk(32'(isolated_a));
        cyc(); #1;
        push("t7_iso_c2", 1); pop_chk(32'(isolated_a));
        isolate_req = 1'b0;
        cyc(); #1;
        push("t7_release", 0); pop_chk(32'(isolated_a));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
